// File: rtl/l2_bus_pkg.sv
// Shared encodings for the L2 system-bus interface.
// Op and snoop codes plus the sequencer state type.
package l2_bus_pkg;

  localparam logic [2:0] BUS_READ       = 3'd1;
  localparam logic [2:0] BUS_WRITE      = 3'd2;
  localparam logic [2:0] BUS_INVALIDATE = 3'd3;
  localparam logic [2:0] BUS_RWIM       = 3'd4;

  localparam logic [1:0] NOHIT = 2'd0;
  localparam logic [1:0] HIT   = 2'd1;
  localparam logic [1:0] HITM  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_ADDR,
    S_SNOOP,
    S_DATA,
    S_RESP
  } state_t;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    return op inside {BUS_READ, BUS_WRITE,
                      BUS_INVALIDATE, BUS_RWIM};
  endfunction

endpackage

// File: rtl/l2_bus_fifo.sv
// Small synchronous FIFO holding queued bus operations.
// No bypass: a full queue refuses pushes even while popping.
module l2_bus_fifo #(
  parameter int W     = 35,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (cnt == (AW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/l2_bus_interface.sv
// L2-to-system-bus sequencer: queues controller ops and runs
// each through arbitration, address, snoop and data phases.
module l2_bus_interface
  import l2_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SNOOP_DLY  = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  output logic [2:0]        rsp_op,
  output logic [1:0]        rsp_snoop,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_addr_valid,
  output logic [2:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        bus_snoop,
  input  logic              bus_done,
  output logic              err
);

  localparam int MX = (TIMEOUT > SNOOP_DLY) ?
                      TIMEOUT : SNOOP_DLY;
  localparam int CW = $clog2(MX) + 1;
  localparam int QW = ADDR_W + 3;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        snoop_q;
  logic [1:0]        snoop_s;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              bad;
  logic [QW-1:0]     head;
  logic [2:0]        head_op;
  logic [ADDR_W-1:0] head_addr;

  assign req_ready = !full;
  assign push = req_valid && req_ready
             && op_legal(req_op);
  assign bad  = req_valid && req_ready
             && !op_legal(req_op);
  assign pop  = (state == S_RESP);
  assign {head_op, head_addr} = head;
  // the undefined snoop code 3 is folded to NOHIT
  assign snoop_s = (bus_snoop == 2'd3) ?
                   NOHIT : bus_snoop;

  l2_bus_fifo #(
    .W     (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({req_op, req_addr}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      snoop_q        <= NOHIT;
      rsp_valid      <= 1'b0;
      rsp_op         <= '0;
      rsp_snoop      <= '0;
      bus_req        <= 1'b0;
      bus_addr_valid <= 1'b0;
      bus_op         <= '0;
      bus_addr       <= '0;
      err            <= 1'b0;
    end else begin
      rsp_valid      <= 1'b0;
      bus_addr_valid <= 1'b0;
      bus_op         <= '0;
      bus_addr       <= '0;
      if (bad) err <= 1'b1;
      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            state   <= S_ARB;
            bus_req <= 1'b1;
          end
        end
        S_ARB: begin
          if (bus_gnt) begin
            state          <= S_ADDR;
            bus_addr_valid <= 1'b1;
            bus_op         <= head_op;
            bus_addr       <= head_addr;
          end
        end
        S_ADDR: begin
          state <= S_SNOOP;
          cnt   <= '0;
        end
        S_SNOOP: begin
          if (cnt == CW'(SNOOP_DLY - 1)) begin
            snoop_q <= snoop_s;
            cnt     <= '0;
            if (bus_snoop == 2'd3) err <= 1'b1;
            if (head_op == BUS_INVALIDATE) begin
              state     <= S_RESP;
              bus_req   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_op    <= head_op;
              rsp_snoop <= snoop_s;
            end else begin
              state <= S_DATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bus_done ||
              cnt == CW'(TIMEOUT - 1)) begin
            if (!bus_done) err <= 1'b1;
            state     <= S_RESP;
            bus_req   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_op    <= head_op;
            rsp_snoop <= snoop_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_bus_interface.sv
// Bench for l2_bus_interface: timestamp-level reference model
// checked every cycle, plus directed latency/ordering cases.
module tb_l2_bus_interface;
  import l2_bus_pkg::*;

  localparam int DLY   = 2;
  localparam int TO    = 15;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic        rsp_valid;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_snoop;
  logic        bus_req;
  logic        bus_gnt = 1'b0;
  logic        bus_addr_valid;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr;
  logic [1:0]  bus_snoop = '0;
  logic        bus_done = 1'b0;
  logic        err;

  l2_bus_interface #(
    .ADDR_W     (32),
    .FIFO_DEPTH (DEPTH),
    .SNOOP_DLY  (DLY),
    .TIMEOUT    (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_op         (rsp_op),
    .rsp_snoop      (rsp_snoop),
    .bus_req        (bus_req),
    .bus_gnt        (bus_gnt),
    .bus_addr_valid (bus_addr_valid),
    .bus_op         (bus_op),
    .bus_addr       (bus_addr),
    .bus_snoop      (bus_snoop),
    .bus_done       (bus_done),
    .err            (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] addr;
  } ent_t;

  ent_t q[$];
  int   mcmp = 0, mfail = 0;
  int   dcmp = 0, dfail = 0;
  int   cyc = 0;
  bit   chk_en = 0, active = 0, m_err = 0;
  int   req_start = -1, addr_cyc = -1;
  int   rsp_due = -1;
  logic [1:0] snp = '0;

  function automatic void mchk(string nm,
    logic [63:0] act, logic [63:0] exp);
    mcmp++;
    if (act !== exp) begin
      mfail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h",
               nm, cyc, act, exp);
    end
  endfunction

  function automatic void dchk(string nm,
    logic [63:0] act, logic [63:0] exp);
    dcmp++;
    if (act !== exp) begin
      dfail++;
      $display("FAIL %s t=%0t got=%0h want=%0h",
               nm, $time, act, exp);
    end
  endfunction

  // Reference model: one transaction at a time, timed
  // from its bus-request start, grant and address cycles.
  always @(negedge clk) begin
    bit e_req, e_av, e_rv, e_rdy;
    cyc++;
    e_rdy = (q.size() < DEPTH);
    e_req = active && cyc >= req_start &&
            (rsp_due < 0 || cyc < rsp_due);
    e_av  = active && addr_cyc == cyc;
    e_rv  = active && rsp_due == cyc;
    if (chk_en) begin
      mchk("req_ready", req_ready, e_rdy);
      mchk("bus_req", bus_req, e_req);
      mchk("bus_addr_valid", bus_addr_valid, e_av);
      mchk("rsp_valid", rsp_valid, e_rv);
      mchk("err", err, m_err);
      if (e_av && bus_addr_valid) begin
        mchk("bus_op", bus_op, q[0].op);
        mchk("bus_addr", bus_addr, q[0].addr);
      end
      if (e_rv && rsp_valid) begin
        mchk("rsp_op", rsp_op, q[0].op);
        mchk("rsp_snoop", rsp_snoop, snp);
      end
    end
    if (rst) begin
      q.delete();
      active = 0;
      m_err  = 0;
      chk_en = 1;
    end else begin
      if (active) begin
        if (addr_cyc < 0 && cyc >= req_start && bus_gnt)
          addr_cyc = cyc + 1;
        if (addr_cyc >= 0 && cyc == addr_cyc + DLY) begin
          snp = (bus_snoop == 2'd3) ? 2'd0 : bus_snoop;
          if (bus_snoop == 2'd3) m_err = 1;
          if (q[0].op == BUS_INVALIDATE)
            rsp_due = cyc + 1;
        end else if (addr_cyc >= 0 && rsp_due < 0 &&
                     cyc > addr_cyc + DLY) begin
          if (bus_done) begin
            rsp_due = cyc + 1;
          end else if (cyc == addr_cyc + DLY + TO) begin
            rsp_due = cyc + 1;
            m_err = 1;
          end
        end
        if (cyc == rsp_due) begin
          void'(q.pop_front());
          active = 0;
        end
      end else if (q.size() > 0) begin
        active    = 1;
        req_start = cyc + 1;
        addr_cyc  = -1;
        rsp_due   = -1;
      end
      if (req_valid && e_rdy) begin
        if (req_op inside {[3'd1:3'd4]})
          q.push_back({req_op, req_addr});
        else
          m_err = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_op(input logic [2:0] op,
                         input logic [31:0] a);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_one(input logic [2:0] op,
    input logic [31:0] a, input int lat_x,
    input logic [1:0] snp_x, input logic err_x,
    input string tag);
    int lat = 0, na = 0;
    bit seen = 0;
    logic [2:0]  aop = '0;
    logic [31:0] aad = '0;
    push_op(op, a);
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (bus_addr_valid) begin
        na++;
        aop = bus_op;
        aad = bus_addr;
      end
      if (rsp_valid) seen = 1;
    end
    dchk({tag, "_latency"}, lat, lat_x);
    dchk({tag, "_rsp_op"}, rsp_op, op);
    dchk({tag, "_rsp_snoop"}, rsp_snoop, snp_x);
    dchk({tag, "_err"}, err, err_x);
    dchk({tag, "_strobes"}, na, 1);
    dchk({tag, "_bus_op"}, aop, op);
    dchk({tag, "_bus_addr"}, aad, a);
    tick();
  endtask

  initial begin
    int ncyc, nrsp, acc, rsp1, act;
    bit hit;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    dchk("rst_ready", req_ready, 1'b1);
    dchk("rst_outs",
         {rsp_valid, rsp_op, rsp_snoop, bus_req,
          bus_addr_valid, bus_op, bus_addr, err}, '0);
    tick();

    bus_gnt = 1'b1; bus_done = 1'b1; bus_snoop = HIT;
    run_one(BUS_READ, 32'h0000_1000, 7, HIT, 1'b0, "read");
    bus_snoop = NOHIT;
    run_one(BUS_INVALIDATE, 32'h0000_2040, 6, NOHIT,
            1'b0, "inval");

    bus_gnt = 1'b0; bus_snoop = HITM;
    for (int i = 0; i < 4; i++)
      push_op(BUS_WRITE, 32'h3000 + 32'(i * 64));
    req_valid = 1'b1;
    req_op    = BUS_WRITE;
    req_addr  = 32'h3100;
    bus_gnt   = 1'b1;
    ncyc = 0; nrsp = 0; acc = -1; rsp1 = -1;
    while (nrsp < 5 && ncyc < 300) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) dchk("full_ready", req_ready, 1'b0);
      if (rsp_valid) begin
        if (nrsp == 0) rsp1 = ncyc;
        dchk("wr_rsp_op", rsp_op, BUS_WRITE);
        nrsp++;
      end
      if (req_valid && req_ready && acc < 0) acc = ncyc;
      tick();
      if (acc >= 0) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    dchk("wr_count", nrsp, 5);
    dchk("fifth_accept", acc, rsp1 + 1);

    bus_done = 1'b0; bus_snoop = HIT;
    run_one(BUS_RWIM, 32'h0000_4080, 21, HIT, 1'b1,
            "timeout");
    do_rst();
    bus_done = 1'b1; bus_snoop = 2'd3;
    run_one(BUS_READ, 32'h0000_5000, 7, NOHIT, 1'b1,
            "snoop3");
    do_rst();

    bus_snoop = HIT;
    push_op(3'd6, 32'h6000);
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus_req || bus_addr_valid) act++;
    end
    dchk("illegal_activity", act, 0);
    dchk("illegal_err", err, 1'b1);
    tick();
    do_rst();

    bus_gnt = 1'b0;
    push_op(BUS_READ, 32'h7000);
    push_op(BUS_READ, 32'h7040);
    bus_gnt = 1'b1;
    hit = 0; ncyc = 0;
    while (!hit && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      if (bus_addr_valid) hit = 1;
    end
    dchk("reach_addr", hit, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    dchk("midrst_ready", req_ready, 1'b1);
    dchk("midrst_outs",
         {rsp_valid, rsp_op, rsp_snoop, bus_req,
          bus_addr_valid, bus_op, bus_addr, err}, '0);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) act++;
    end
    dchk("midrst_no_rsp", act, 0);
    tick();

    repeat (3000) begin
      int r;
      r = int'($urandom_range(0, 15));
      req_valid = ($urandom_range(0, 2) == 0);
      if (r == 0)
        req_op = ($urandom_range(0, 1) == 0) ? 3'd0 :
                 3'($urandom_range(5, 7));
      else
        req_op = 3'(1 + r % 4);
      req_addr  = $urandom() & 32'hFFFF_FFC0;
      bus_gnt   = ($urandom_range(0, 1) == 1);
      bus_snoop = 2'($urandom_range(0, 3));
      bus_done  = ($urandom_range(0, 3) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    req_valid = 1'b0; rst = 1'b0;
    bus_gnt = 1'b1; bus_done = 1'b1;
    repeat (100) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             mcmp + dcmp, mfail + dfail);
    $finish;
  end

endmodule

// File: doc/l2_bus_interface.md
# l2_bus_interface

Sits directly downstream of the L2 cache controller. Takes the controller's bus operations (READ, WRITE writeback, INVALIDATE, RWIM) and queues them in order in a small FIFO. Runs each one in turn on the shared system bus through a request/grant, address, snoop and data sequence, then returns the sampled snoop result to the controller. This block is the only path from the L2 to the system bus.

## Interface
- `ADDR_W`, 32, bus/line address width
- `FIFO_DEPTH`, 4, request queue entries (power of two, ≥2)
- `SNOOP_DLY`, 2, cycles from address phase to snoop sample (≥1)
- `TIMEOUT`, 15, max cycles waiting for `bus_done` in data phase
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  controller presents an operation
- `req_ready`  out  1  queue can accept; transfer when valid&ready
- `req_op`  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; others illegal
- `req_addr`  in  ADDR_W  line address (offset bits already zero)
- `rsp_valid`  out  1  one-cycle pulse, operation retired
- `rsp_op`  out  3  op being retired
- `rsp_snoop`  out  2  0=NOHIT, 1=HIT, 2=HITM
- `bus_req`  out  1  bus request to arbiter
- `bus_gnt`  in  1  arbiter grant
- `bus_addr_valid`  out  1  address phase strobe
- `bus_op`  out  3  op on bus, valid with strobe
- `bus_addr`  out  ADDR_W  address on bus, valid with strobe
- `bus_snoop`  in  2  wired snoop result from other caches
- `bus_done`  in  1  data phase complete
- `err`  out  1  sticky error flag

## Operation
- Queue: FIFO of {op, addr}. `req_ready = !full`, with no same-cycle bypass when full even if a pop occurs. Requests with an illegal `req_op` are dropped (not enqueued), set `err`, and are still accepted (handshake completes).
- FSM states:
  - IDLE: if queue non-empty, go to ARB.
  - ARB: `bus_req`=1; on `bus_gnt`, go to ADDR.
  - ADDR: one cycle with `bus_addr_valid`=1 and `bus_op`/`bus_addr` driven from the queue head; go to SNOOP. `bus_req` stays 1 from ARB through DATA.
  - SNOOP: counter runs 1..SNOOP_DLY; `bus_snoop` is sampled on the SNOOP_DLY-th cycle. Value 3 is recorded as NOHIT and sets `err`. Then INVALIDATE goes to RESP; all other ops go to DATA.
  - DATA: wait for `bus_done`, then go to RESP. If TIMEOUT cycles pass with no `bus_done`, set `err` and go to RESP.
  - RESP: `rsp_valid`=1 for one cycle with the head's op and the sampled snoop; pop the head; go to IDLE.
- Strict FIFO order; exactly one bus transaction outstanding.
- `bus_gnt` is ignored outside ARB. `bus_done` is ignored outside DATA.
- `err` clears only on `rst`.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_op`=0, `rsp_snoop`=0, `bus_req`=0, `bus_addr_valid`=0, `bus_op`=0, `bus_addr`=0, `err`=0; FIFO empty; FSM in IDLE.
- All outputs are registered.
- Push at cycle t into an empty queue with an idle FSM: `bus_req` rises at t+2. With grant in the same cycle, ADDR is at t+3.
- Minimum latency, enqueue to `rsp_valid`, with grant and `bus_done` immediate: INVALIDATE = 4+SNOOP_DLY; others = 5+SNOOP_DLY.
- Full queue with pop in RESP: `req_ready` rises the cycle after the pop.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo FIFO_DEPTH.
- `rst` mid-transaction: all state drops to reset values next edge. No `rsp_valid` is issued for in-flight or queued ops.

## Structure
- Shared package `l2_bus_pkg`:
  - op encodings `BUS_READ`, `BUS_WRITE`, `BUS_INVALIDATE`, `BUS_RWIM`
  - snoop encodings `NOHIT`, `HIT`, `HITM`
  - FSM state type
- One sub-module, `l2_bus_fifo` (parameterised sync FIFO with full/empty); the FSM, counters and output registers stay in the top.

## Test plan
- Single READ 0x0000_1000: `bus_gnt` held 1, `bus_snoop`=HIT, `bus_done` at first DATA cycle (SNOOP_DLY=2) -> one `bus_addr_valid` with op 1 and addr 0x1000; `rsp_valid` 7 cycles after push with `rsp_op`=1, `rsp_snoop`=1.
- INVALIDATE 0x0000_2040 with `bus_snoop`=NOHIT -> DATA is skipped, `rsp_valid` 6 cycles after push, `rsp_snoop`=0.
- Push 5 WRITEs back-to-back with `bus_gnt` held 0 -> `req_ready` drops after the 4th. Raise grant -> responses retire in push order with matching addresses, and the 5th is accepted the cycle after the first pop.
- RWIM with `bus_done` never asserted -> `err`=1 after 15 DATA cycles; `rsp_valid` still pulses with `rsp_op`=4.
- `bus_snoop`=3 at the sample point -> `rsp_snoop`=0 and `err`=1. Separately, `req_op`=6 -> dropped, `err`=1, and no bus activity.
- Assert `rst` during SNOOP with 2 ops queued -> the following cycle all outputs are at reset values, and no `rsp_valid` appears within 20 cycles.
